uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter and next generation of uart_tx. It adds configurable data width, parity and stop bits, plus an input FIFO so software or upstream logic can queue bytes without waiting on busy. Frames go out back-to-back with no idle gap while the FIFO holds data. It sits beside uart_rx on the serial_tx line.

Parameters:
CLKS_PER_BIT, 1000, clk cycles per serial bit (>=2)
DATA_BITS, 8, data bits per frame (5..9)
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame (1 or 2)
FIFO_DEPTH, 4, FIFO entries (power of 2, >=2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
outgoing  input  DATA_BITS  word to queue
flush  input  1  write strobe; pushes outgoing when sampled high
full  output  1  FIFO holds FIFO_DEPTH words
level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  output  1  one-cycle pulse when a flush is dropped
busy  output  1  high while a frame is on the line or the FIFO is non-empty
serial_tx  output  1  serial line, idle high

Behaviour:
- Reset (async, rst_n low): serial_tx=1, busy=0, full=0, level=0, overflow=0, FIFO emptied, FSM=IDLE. Reset mid-frame aborts the frame and the line goes high immediately. No partial frame resumes after reset.
- Push: flush high at edge n while full=0 writes outgoing; level increments at n+1.
- Full rule: the full check uses registered state. A flush while full=1 is dropped even if a pop happens the same cycle. overflow pulses high for exactly cycle n+1.
- Simultaneous push and pop when not full: both take effect and level is unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: serial_tx=1. If the FIFO is non-empty, pop the head into the shift register and enter START at the next edge. First-word latency: flush at edge n into an empty IDLE block gives serial_tx low from edge n+2.
- START: serial_tx=0 for CLKS_PER_BIT cycles.
- DATA: DATA_BITS bits, LSB first, each held CLKS_PER_BIT cycles.
- PARITY: present only when PARITY!=0. Odd mode drives the XNOR-reduce of the data; even mode drives the XOR-reduce. One bit period.
- STOP: serial_tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the last cycle, if the FIFO is non-empty, pop and go straight to START. Otherwise go to IDLE.
- Frame length: (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles exactly.
- The bit-period counter is $clog2(CLKS_PER_BIT) wide and wraps to 0 at CLKS_PER_BIT-1. The bit index counts 0..DATA_BITS-1.
- busy = (FSM!=IDLE) | (level!=0). It falls on the cycle after the last stop bit of the last queued frame.
- outgoing is sampled only at push. Later changes do not affect queued words.

Optional Feature:
Macro UART_TX_BREAK_EN.
- With the macro: adds input port send_break (1 bit). If send_break is high while the FSM is in IDLE, the block enters state BREAK.
- BREAK behaviour: serial_tx=0, and the state holds while send_break stays high. The minimum break length is one full frame length. The FIFO is not popped during BREAK, and busy=1. Afterwards the FSM returns to IDLE with serial_tx=1 for at least 1 bit period before the next START.
- Priority: a break request outranks a pending FIFO word in IDLE.
- Without the macro: no send_break port, no BREAK state.

Test Plan:
- CLKS_PER_BIT=4, 8N1; push 0xD5 into an idle block -> serial_tx goes low 2 edges after flush. Each bit lasts 4 clk. Line sequence: 0, 1,0,1,0,1,0,1,1, 1. Frame is 40 cycles; busy then falls.
- PARITY=2, push 0xD5 (five 1s) -> parity bit 1, frame 44 cycles. With PARITY=1 -> parity bit 0.
- FIFO_DEPTH=4; flush high for 6 consecutive cycles with bytes 0x01..0x06 -> 0x01 popped immediately, 0x02..0x05 queued, full=1. 0x06 dropped with a single overflow pulse. Five frames go out contiguously with no idle cycle between stop and start.
- DATA_BITS=7, STOP_BITS=2, push 0x7F -> line: start 0, seven 1s, two stop 1s. Frame is 40 cycles; the next start bit is not earlier than cycle 40.
- Reset: assert rst_n=0 during bit 3 of a frame with 2 words queued -> serial_tx=1, level=0, busy=0 immediately. After release, no frame starts until a new flush.
- UART_TX_BREAK_EN: hold send_break for 10 cycles in idle (8N1, CLKS_PER_BIT=4) -> serial_tx low for 40 cycles, then high for at least 4 cycles. A word pushed during the break is sent after that.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-fed UART transmitter with width/parity/stop options.
// Define UART_TX_BREAK_EN to add the send_break line-break request.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 1000,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          outgoing,
    input  logic                          flush,
`ifdef UART_TX_BREAK_EN
    input  logic                          send_break,
`endif
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          busy,
    output logic                          serial_tx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = $clog2(DATA_BITS);
`ifdef UART_TX_BREAK_EN
    localparam int FRAME_LEN =
        (1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS) * CLKS_PER_BIT;
    localparam int BW = $clog2(FRAME_LEN);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_TX_BREAK_EN
        , S_BREAK
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 stp_q, stp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic [AW-1:0]        wr_q, rd_q;
    logic [LW-1:0]        level_q, level_d;
    logic                 ovf_q;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

    logic push, pop, bit_end, last_bit, stop_last;
    logic fifo_ne, full_w, cnt_run, idle_ok, brk_req;

`ifdef UART_TX_BREAK_EN
    logic [BW-1:0] brk_q;
    logic          hold_q;
    logic          brk_done;

    assign brk_req  = send_break;
    assign brk_done = brk_q == BW'(FRAME_LEN - 1);
    // After a break the line idles one full bit period before any START.
    assign idle_ok  = !hold_q || bit_end;
    assign cnt_run  = (state_q == S_IDLE) ? hold_q : (state_q != S_BREAK);
`else
    assign brk_req  = 1'b0;
    assign idle_ok  = 1'b1;
    assign cnt_run  = state_q != S_IDLE;
`endif

    assign full_w    = level_q == LW'(FIFO_DEPTH);
    assign fifo_ne   = level_q != '0;
    assign push      = flush && !full_w;
    assign bit_end   = cnt_q == CW'(CLKS_PER_BIT - 1);
    assign last_bit  = idx_q == IW'(DATA_BITS - 1);
    assign stop_last = (STOP_BITS == 1) || stp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (brk_req) begin
`ifdef UART_TX_BREAK_EN
                    state_d = S_BREAK;
`endif
                end else if (fifo_ne && idle_ok) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: if (bit_end) state_d = S_DATA;
            S_DATA: begin
                if (bit_end && last_bit)
                    state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (bit_end) state_d = S_STOP;
            S_STOP: begin
                if (bit_end && stop_last) begin
                    if (fifo_ne) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            S_BREAK: if (brk_done && !send_break) state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
            S_PARITY: tx_d = par_q;
`ifdef UART_TX_BREAK_EN
            S_BREAK:  tx_d = 1'b0;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        cnt_d   = '0;
        idx_d   = idx_q;
        stp_d   = stp_q;
        shift_d = shift_q;
        par_d   = par_q;
        level_d = level_q + LW'(push) - LW'(pop);
        if (cnt_run && !bit_end) cnt_d = cnt_q + CW'(1);
        if (state_q == S_DATA && bit_end)
            idx_d = last_bit ? '0 : idx_q + IW'(1);
        if (state_q == S_STOP && bit_end) stp_d = !stop_last;
        if (pop) begin
            shift_d = mem[rd_q];
            par_d   = (PARITY == 1) ? ~^mem[rd_q] : ^mem[rd_q];
        end else if (state_q == S_DATA && bit_end) begin
            shift_d = shift_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            stp_q   <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stp_q   <= stp_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            level_q <= level_d;
            ovf_q   <= flush && full_w;
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= outgoing;
    end

`ifdef UART_TX_BREAK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brk_q  <= '0;
            hold_q <= 1'b0;
        end else begin
            if (state_q != S_BREAK) brk_q <= '0;
            else if (!brk_done)     brk_q <= brk_q + BW'(1);
            if (state_q == S_BREAK && state_d == S_IDLE) hold_q <= 1'b1;
            else if (state_q == S_IDLE && bit_end)       hold_q <= 1'b0;
        end
    end
`endif

    assign full      = full_w;
    assign level     = level_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q != S_IDLE) || fifo_ne;
    assign serial_tx = tx_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1, 8E1, 8O1 and 7N2 instances.
// Break checks are compiled in when UART_TX_BREAK_EN is defined.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic [6:0] data_s;
    logic       fl_a, fl_p, fl_s, brk_a;

    logic       full_a, ovf_a, busy_a, tx_a;
    logic [2:0] level_a;
    logic       full_e, ovf_e, busy_e, tx_e;
    logic [2:0] level_e;
    logic       full_o, ovf_o, busy_o, tx_o;
    logic [2:0] level_o;
    logic       full_s, ovf_s, busy_s, tx_s;
    logic [2:0] level_s;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          n0, m;
    logic        log_a [0:1023];
    logic [15:0] pat, pat2;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst_n(rst_n), .outgoing(data), .flush(fl_a),
`ifdef UART_TX_BREAK_EN
        .send_break(brk_a),
`endif
        .full(full_a), .level(level_a), .overflow(ovf_a),
        .busy(busy_a), .serial_tx(tx_a));

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
        .clk(clk), .rst_n(rst_n), .outgoing(data), .flush(fl_p),
`ifdef UART_TX_BREAK_EN
        .send_break(1'b0),
`endif
        .full(full_e), .level(level_e), .overflow(ovf_e),
        .busy(busy_e), .serial_tx(tx_e));

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_o (
        .clk(clk), .rst_n(rst_n), .outgoing(data), .flush(fl_p),
`ifdef UART_TX_BREAK_EN
        .send_break(1'b0),
`endif
        .full(full_o), .level(level_o), .overflow(ovf_o),
        .busy(busy_o), .serial_tx(tx_o));

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u_s (
        .clk(clk), .rst_n(rst_n), .outgoing(data_s), .flush(fl_s),
`ifdef UART_TX_BREAK_EN
        .send_break(1'b0),
`endif
        .full(full_s), .level(level_s), .overflow(ovf_s),
        .busy(busy_s), .serial_tx(tx_s));

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
        log_a[cyc % 1024] = tx_a;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; data = '0; data_s = '0;
        fl_a = 0; fl_p = 0; fl_s = 0; brk_a = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx", tx_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_full", full_a, 0);
        check("rst_level", level_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_tx_s", tx_s, 1);
        rst_n = 1'b1;
        tick;

        // 8N1, 0xD5
        data = 8'hD5; fl_a = 1; tick; fl_a = 0;
        check("push_level", level_a, 1);
        check("push_busy", busy_a, 1);
        tick;
        check("lat_idle", tx_a, 1);
        check("pop_level", level_a, 0);
        tick;
        pat = 16'h03AA;
        for (int j = 0; j < 40; j++) begin
            check($sformatf("8n1_c%0d", j), tx_a, pat[j/4]);
            if (j == 38) check("8n1_busy_hi", busy_a, 1);
            if (j == 39) check("8n1_busy_lo", busy_a, 0);
            tick;
        end
        check("8n1_idle", tx_a, 1);

        // 8E1 and 8O1, 0xD5
        data = 8'hD5; fl_p = 1; tick; fl_p = 0;
        check("par_level", level_e, 1);
        tick; tick;
        pat  = 16'h07AA;
        pat2 = 16'h05AA;
        for (int j = 0; j < 44; j++) begin
            check($sformatf("8e1_c%0d", j), tx_e, pat[j/4]);
            check($sformatf("8o1_c%0d", j), tx_o, pat2[j/4]);
            if (j == 42) check("8e1_busy_hi", busy_e, 1);
            if (j == 43) check("8o1_busy_lo", busy_o, 0);
            tick;
        end
        check("par_idle", tx_e, 1);

        // 7N2, 0x7F then 0x00 back to back
        data_s = 7'h7F; fl_s = 1; tick;
        data_s = 7'h00; tick; fl_s = 0;
        check("7n2_level", level_s, 1);
        tick;
        pat = 16'h03FE;
        for (int j = 0; j < 44; j++) begin
            check($sformatf("7n2_c%0d", j), tx_s, pat[j/4]);
            tick;
        end
        for (int i = 0; i < 200 && busy_s; i++) tick;
        check("7n2_drain", busy_s, 0);

        // FIFO fill, overflow, contiguous frames
        for (int c = 0; c < 6; c++) begin
            data = 8'(c + 1); fl_a = 1; tick;
            if (c == 0) n0 = cyc;
            if (c == 1) check("pushpop_level", level_a, 1);
            if (c == 3) check("l3_full", full_a, 0);
            if (c == 4) begin
                check("l4_full", full_a, 1);
                check("l4_level", level_a, 4);
                check("l4_ovf", ovf_a, 0);
            end
            if (c == 5) begin
                check("drop_ovf", ovf_a, 1);
                check("drop_level", level_a, 4);
            end
        end
        fl_a = 0; tick;
        check("ovf_pulse_end", ovf_a, 0);
        check("ovf_level", level_a, 4);
        repeat (205) tick;
        for (int k = 0; k < 5; k++) begin
            pat = 16'h0200 | 16'((k + 1) << 1);
            for (int j = 0; j < 40; j++)
                check($sformatf("fifo_f%0d_c%0d", k, j),
                      log_a[(n0 + 2 + 40 * k + j) % 1024], pat[j/4]);
        end
        for (int j = 0; j < 8; j++)
            check($sformatf("fifo_tail%0d", j),
                  log_a[(n0 + 202 + j) % 1024], 1);
        check("fifo_busy", busy_a, 0);
        check("fifo_level", level_a, 0);

        // Reset mid-frame with two words queued
        data = 8'hA0; fl_a = 1;
        repeat (3) tick;
        fl_a = 0;
        check("pre_rst_level", level_a, 2);
        repeat (17) tick;
        check("pre_rst_tx", tx_a, 0);
        check("pre_rst_busy", busy_a, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tx", tx_a, 1);
        check("mid_rst_level", level_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_full", full_a, 0);
        #20 rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick;
            check($sformatf("post_rst_tx%0d", i), tx_a, 1);
            if (i % 10 == 0) check("post_rst_busy", busy_a, 0);
        end

`ifdef UART_TX_BREAK_EN
        m = cyc; brk_a = 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin data = 8'h55; fl_a = 1; end
            tick;
            fl_a = 0;
            if (i == 1) check("brk_busy", busy_a, 1);
            if (i == 6) check("brk_nopop", level_a, 1);
        end
        brk_a = 0;
        repeat (100) tick;
        for (int j = 0; j < 40; j++)
            check($sformatf("brk_low%0d", j), log_a[(m + 2 + j) % 1024], 0);
        for (int j = 0; j < 4; j++)
            check($sformatf("brk_gap%0d", j), log_a[(m + 42 + j) % 1024], 1);
        pat = 16'h02AA;
        for (int j = 0; j < 40; j++)
            check($sformatf("brk_frame%0d", j),
                  log_a[(m + 46 + j) % 1024], pat[j/4]);
        check("brk_done_busy", busy_a, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end
endmodule
